// File: rtl/frame_pace_ctrl_pkg.sv
// Shared constants for the frame pacing controller:
// register map, CTRL/STATUS bit positions and FSM states.
package frame_pace_ctrl_pkg;

  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_MISS   = 3'd2;
  localparam logic [2:0] A_LATE   = 3'd3;
  localparam logic [2:0] A_SHOWN  = 3'd4;
  localparam logic [2:0] A_FRAMES = 3'd5;

  localparam int C_EN    = 0;
  localparam int C_IRQ   = 1;
  localparam int C_FLUSH = 2;

  localparam int S_NE    = 0;
  localparam int S_UNDER = 1;
  localparam int S_LATE  = 2;
  localparam int S_BUSY  = 3;

  localparam int SHOWN_V = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWAP  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/frame_pace_ctrl_if.sv
// Bus bundle for frame_pace_ctrl: Avalon-MM slave,
// decoder push, display swap and buffer-return signals.
interface frame_pace_ctrl_if #(
  parameter int IDX_W = 2
);
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [15:0]      writedata;
  logic [15:0]      readdata;
  logic             irq;
  logic             tick_in;
  logic             frame_valid;
  logic [IDX_W-1:0] frame_idx;
  logic             frame_ready;
  logic             swap_req;
  logic [IDX_W-1:0] swap_idx;
  logic             swap_ack;
  logic             free_valid;
  logic [IDX_W-1:0] free_idx;

  modport slave (
    input  address, chipselect, write_n, writedata,
    input  tick_in, frame_valid, frame_idx, swap_ack,
    output readdata, irq, frame_ready,
    output swap_req, swap_idx, free_valid, free_idx
  );

  modport master (
    output address, chipselect, write_n, writedata,
    output tick_in, frame_valid, frame_idx, swap_ack,
    input  readdata, irq, frame_ready,
    input  swap_req, swap_idx, free_valid, free_idx
  );
endinterface

// File: rtl/frame_idx_fifo.sv
// Synchronous FIFO of frame-buffer indices with
// count-based full/empty; push and pop may coincide.
module frame_idx_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/frame_pace_ctrl.sv
// Frame pacing: one display swap per timer tick from a
// queue of decoded buffers; retires buffers, counts misses.
module frame_pace_ctrl
  import frame_pace_ctrl_pkg::*;
#(
  parameter int IDX_W      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  frame_pace_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic             tick_q;
  logic             en_q, en_d;
  logic             irq_en_q, irq_en_d;
  logic             under_q, under_d;
  logic             latef_q, latef_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic [CNT_W-1:0] late_q, late_d;
  logic [15:0]      frames_q, frames_d;
  logic [15:0]      readdata_q, readdata_d;
  logic [IDX_W-1:0] swap_idx_q, swap_idx_d;
  logic             shown_v_q, shown_v_d;
  logic [IDX_W-1:0] shown_idx_q, shown_idx_d;
  logic             free_v_q, free_v_d;
  logic [IDX_W-1:0] free_idx_q, free_idx_d;

  logic [IDX_W-1:0] head;
  logic             empty, full, push, pop;
  logic             tick_evt, wr, flush_req;
  logic             clr_stat, clr_cnt;
  logic             load_swap, miss_evt, late_evt;
  logic             ack_evt, frame_ready, swap_req;
  logic             unused_wdata;

  assign tick_evt  = bus.tick_in & ~tick_q & en_q;
  assign wr        = bus.chipselect & ~bus.write_n;
  assign flush_req = wr & (bus.address == A_CTRL)
                   & bus.writedata[C_FLUSH];
  assign clr_stat  = wr & (bus.address == A_STATUS);
  assign clr_cnt   = wr & ((bus.address == A_MISS) |
                           (bus.address == A_LATE));
  assign push      = bus.frame_valid & frame_ready;
  assign unused_wdata = ^bus.writedata[15:3];

  frame_idx_fifo #(
    .W     (IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (push),
    .pop   (pop),
    .din   (bus.frame_idx),
    .dout  (head),
    .empty (empty),
    .full  (full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Occupancy is taken before any same-cycle push.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (tick_evt && !empty) state_d = ST_SWAP;
        else if (flush_req)     state_d = ST_FLUSH;
      end
      ST_SWAP:  if (bus.swap_ack) state_d = ST_IDLE;
      ST_FLUSH: if (empty)        state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_ready = en_q & ~full & (state_q != ST_FLUSH);
    swap_req    = 1'b0;
    pop         = 1'b0;
    load_swap   = 1'b0;
    miss_evt    = 1'b0;
    late_evt    = 1'b0;
    ack_evt     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        load_swap = tick_evt & ~empty;
        pop       = load_swap;
        miss_evt  = tick_evt & empty;
      end
      ST_SWAP: begin
        swap_req = 1'b1;
        late_evt = tick_evt;
        ack_evt  = bus.swap_ack;
      end
      ST_FLUSH: begin
        pop      = ~empty;
        miss_evt = tick_evt;
      end
      default: ;
    endcase
  end

  always_comb begin
    en_d        = en_q;
    irq_en_d    = irq_en_q;
    swap_idx_d  = load_swap ? head : swap_idx_q;
    shown_v_d   = shown_v_q;
    shown_idx_d = shown_idx_q;
    frames_d    = frames_q;
    free_v_d    = 1'b0;
    free_idx_d  = free_idx_q;
    if (wr && bus.address == A_CTRL) begin
      en_d     = bus.writedata[C_EN];
      irq_en_d = bus.writedata[C_IRQ];
    end
    // A set event in the same cycle beats the clear.
    under_d = miss_evt | (under_q & ~clr_stat);
    latef_d = late_evt | (latef_q & ~clr_stat);
    miss_d  = clr_cnt ? '0 : miss_q;
    late_d  = clr_cnt ? '0 : late_q;
    if (miss_evt && miss_d != '1)
      miss_d = miss_d + CNT_W'(1);
    if (late_evt && late_d != '1)
      late_d = late_d + CNT_W'(1);
    if (ack_evt) begin
      free_v_d    = shown_v_q;
      free_idx_d  = shown_v_q ? shown_idx_q : free_idx_q;
      shown_v_d   = 1'b1;
      shown_idx_d = swap_idx_q;
      frames_d    = frames_q + 16'd1;
    end
    if (state_q == ST_FLUSH && !empty) begin
      free_v_d   = 1'b1;
      free_idx_d = head;
    end
  end

  always_comb begin
    readdata_d = '0;
    if (bus.chipselect) begin
      case (bus.address)
        A_STATUS: begin
          readdata_d[S_BUSY]  = (state_q == ST_SWAP);
          readdata_d[S_LATE]  = latef_q;
          readdata_d[S_UNDER] = under_q;
          readdata_d[S_NE]    = ~empty;
        end
        A_CTRL: begin
          readdata_d[C_EN]  = en_q;
          readdata_d[C_IRQ] = irq_en_q;
        end
        A_MISS:   readdata_d = 16'(miss_q);
        A_LATE:   readdata_d = 16'(late_q);
        A_SHOWN: begin
          readdata_d[SHOWN_V]     = shown_v_q;
          readdata_d[IDX_W-1:0]   = shown_idx_q;
        end
        A_FRAMES: readdata_d = frames_q;
        default:  readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q      <= 1'b0;
      en_q        <= 1'b0;
      irq_en_q    <= 1'b0;
      under_q     <= 1'b0;
      latef_q     <= 1'b0;
      miss_q      <= '0;
      late_q      <= '0;
      frames_q    <= '0;
      readdata_q  <= '0;
      swap_idx_q  <= '0;
      shown_v_q   <= 1'b0;
      shown_idx_q <= '0;
      free_v_q    <= 1'b0;
      free_idx_q  <= '0;
    end else begin
      tick_q      <= bus.tick_in;
      en_q        <= en_d;
      irq_en_q    <= irq_en_d;
      under_q     <= under_d;
      latef_q     <= latef_d;
      miss_q      <= miss_d;
      late_q      <= late_d;
      frames_q    <= frames_d;
      readdata_q  <= readdata_d;
      swap_idx_q  <= swap_idx_d;
      shown_v_q   <= shown_v_d;
      shown_idx_q <= shown_idx_d;
      free_v_q    <= free_v_d;
      free_idx_q  <= free_idx_d;
    end
  end

  assign bus.readdata    = readdata_q;
  assign bus.irq         = irq_en_q & (under_q | latef_q);
  assign bus.frame_ready = frame_ready;
  assign bus.swap_req    = swap_req;
  assign bus.swap_idx    = swap_idx_q;
  assign bus.free_valid  = free_v_q;
  assign bus.free_idx    = free_idx_q;

endmodule
